// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the registered source-select bus controller:
//   source codes, controller state encoding and the default slow-source mask.
// ----------------------------------------------------------------------------
package bus_pkg;

    // Source codes presented on sel. Code k reads src_data slot k-1.
    localparam int SRC_NONE = 0;
    localparam int SRC_AR   = 1;
    localparam int SRC_AC   = 2;
    localparam int SRC_PC   = 3;
    localparam int SRC_DR   = 4;
    localparam int SRC_R    = 5;
    localparam int SRC_IRAM = 6;
    localparam int SRC_DRAM = 7;
    localparam int SRC_IR   = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Bit k-1 set marks source code k as memory-backed (IRAM and DRAM).
    localparam logic [7:0] DEFAULT_MEM_MASK = 8'b0110_0000;

endpackage : bus_pkg

// File: rtl/bus_wait_ctr.sv
// ----------------------------------------------------------------------------
// bus_wait_ctr
//   Loadable down-counter that times the wait states of a slow transfer.
//   It stops at zero and reports zero through a flag.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   load   in   load value into the count (takes priority over en)
//   value  in   W  load value
//   en     in   decrement by one while the count is non-zero
//   zero   out  count is zero
// ----------------------------------------------------------------------------
module bus_wait_ctr
    import bus_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its inputs as they were just before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule : bus_wait_ctr

// File: rtl/bus_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// bus_xfer_ctrl
//   Registered source-select bus. A select code accepted through the
//   sel_valid/sel_ready handshake routes one of N_SRC sources onto data_out.
//   Memory-backed sources (MEM_MASK) take MEM_LAT extra cycles, during which
//   the block is busy and refuses new selects; the slow source is sampled at
//   the end of the wait, not at accept. Every accepted select also latches the
//   AR source onto addr. Codes above N_SRC return zero and pulse err.
//
//   SEL_W must satisfy 2**SEL_W > N_SRC.
//
// Optional feature (macro BUS_PARITY_EN)
//   When defined, adds output data_par: even parity (XOR-reduce) of each value
//   written to data_out, registered on the same edge, reset to 0.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset; aborts any transfer
//   src_data    in   N_SRC*DATA_W  source code k at [(k-1)*DATA_W +: DATA_W]
//   sel         in   SEL_W  source code, 0 = none (bus reads zero)
//   sel_valid   in   select request
//   sel_ready   out  block can accept a select (idle)
//   data_out    out  DATA_W  registered bus data
//   data_valid  out  one-cycle pulse: data_out updated
//   addr        out  DATA_W  registered address (AR source)
//   busy        out  wait-state transfer in progress
//   err         out  one-cycle pulse with data_valid for an illegal code
//   data_par    out  parity of data_out (BUS_PARITY_EN only)
// ----------------------------------------------------------------------------
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int               DATA_W   = 16,
    parameter int               N_SRC    = 8,
    parameter int               SEL_W    = 4,
    parameter logic [N_SRC-1:0] MEM_MASK = N_SRC'(DEFAULT_MEM_MASK),
    parameter int               MEM_LAT  = 2,
    parameter int               AR_IDX   = SRC_AR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    output logic [DATA_W-1:0]       data_out,
    output logic                    data_valid,
    output logic [DATA_W-1:0]       addr,
    output logic                    busy,
    output logic                    err
`ifdef BUS_PARITY_EN
    ,
    output logic                    data_par
`endif
);

    // The counter needs at least one bit even when no wait states exist.
    localparam int               CTR_W    = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CTR_W-1:0] CTR_INIT = (MEM_LAT > 0) ? CTR_W'(MEM_LAT - 1) : '0;
    localparam logic [SEL_W-1:0] MAX_CODE = SEL_W'(N_SRC);

    // Source read by code. Only legal codes select a slot, so no out-of-range
    // slice is ever formed; code 0 and illegal codes read zero.
    function automatic logic [DATA_W-1:0] src_pick(
        input logic [N_SRC*DATA_W-1:0] bus,
        input logic [SEL_W-1:0]        code
    );
        logic [DATA_W-1:0] v;
        v = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (code == SEL_W'(k)) v = bus[(k-1)*DATA_W +: DATA_W];
        end
        return v;
    endfunction

    function automatic logic is_slow(input logic [SEL_W-1:0] code);
        logic s;
        s = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (code == SEL_W'(k)) s = MEM_MASK[k-1];
        end
        return s;
    endfunction

    state_t            state, state_d;
    logic [SEL_W-1:0]  code_q;
    logic              ctr_load, ctr_en, ctr_zero;
    logic              addr_we, code_we, data_we, err_d;
    logic [DATA_W-1:0] data_d;

    bus_wait_ctr #(
        .W (CTR_W)
    ) u_wait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ctr_load),
        .value (CTR_INIT),
        .en    (ctr_en),
        .zero  (ctr_zero)
    );

    // Handshake flags follow directly from the registered state.
    assign sel_ready = (state == ST_IDLE);
    assign busy      = (state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // NOTE: every signal gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        addr_we  = 1'b0;
        code_we  = 1'b0;
        data_we  = 1'b0;
        data_d   = '0;
        err_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    addr_we = 1'b1;
                    if (is_slow(sel) && (MEM_LAT > 0)) begin
                        ctr_load = 1'b1;
                        code_we  = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        data_we = 1'b1;
                        data_d  = src_pick(src_data, sel);
                        err_d   = (sel > MAX_CODE);
                    end
                end
            end
            ST_WAIT: begin
                if (ctr_zero) begin
                    // Memory source is sampled now, at the end of the wait.
                    data_we = 1'b1;
                    data_d  = src_pick(src_data, code_q);
                    state_d = ST_IDLE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the latched code and bus registers are reset as well, so an
    // aborted transfer leaves nothing stale behind for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q     <= '0;
            data_out   <= '0;
            addr       <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            data_valid <= data_we;
            err        <= err_d;
            if (code_we) code_q   <= sel;
            if (data_we) data_out <= data_d;
            if (addr_we) addr     <= src_data[(AR_IDX-1)*DATA_W +: DATA_W];
        end
    end

`ifdef BUS_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       data_par <= 1'b0;
        else if (data_we) data_par <= ^data_d;
    end
`endif

endmodule : bus_xfer_ctrl

// File: tb/tb_bus_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bus_xfer_ctrl
//   Directed self-checking bench for bus_xfer_ctrl with default parameters
//   (DATA_W=16, N_SRC=8, MEM_LAT=2, IRAM/DRAM slow, AR = code 1).
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge.
// ----------------------------------------------------------------------------
module tb_bus_xfer_ctrl;

    logic         clk;
    logic         rst_n;
    logic [127:0] src_data;
    logic [3:0]   sel;
    logic         sel_valid;
    logic         sel_ready;
    logic [15:0]  data_out;
    logic         data_valid;
    logic [15:0]  addr;
    logic         busy;
    logic         err;
`ifdef BUS_PARITY_EN
    logic         data_par;
`endif

    int checks = 0;
    int errors = 0;

    bus_xfer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data   (src_data),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .addr       (addr),
        .busy       (busy),
        .err        (err)
`ifdef BUS_PARITY_EN
        ,
        .data_par   (data_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_src(input int k, input logic [15:0] v);
        src_data[(k-1)*16 +: 16] = v;
    endtask

    task automatic drive(input logic [3:0] s, input logic v);
        @(negedge clk);
        sel       = s;
        sel_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full output set after a sample point.
    task automatic expect_out(input string tag, input logic dv, input logic [15:0] d,
                              input logic e, input logic b, input logic rdy);
        check({tag, ".dv"},   {31'd0, data_valid}, {31'd0, dv});
        check({tag, ".data"}, {16'd0, data_out},   {16'd0, d});
        check({tag, ".err"},  {31'd0, err},        {31'd0, e});
        check({tag, ".busy"}, {31'd0, busy},       {31'd0, b});
        check({tag, ".rdy"},  {31'd0, sel_ready},  {31'd0, rdy});
    endtask

    initial begin
        rst_n     = 1'b0;
        src_data  = '0;
        sel       = '0;
        sel_valid = 1'b0;

        // Reset held: everything cleared, ready high.
        tick();
        tick();
        expect_out("rst_hold", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("rst_hold.addr", {16'd0, addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_out("rst_rel", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Fast select of AC; addr picks up AR.
        set_src(1, 16'h0040);
        set_src(2, 16'hBEEF);
        drive(4'd2, 1'b1);
        tick();
        expect_out("fast", 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        check("fast.addr", {16'd0, addr}, 32'h0040);
        drive(4'd0, 1'b0);
        tick();
        expect_out("fast_after", 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b1);

        // Slow select of DRAM: two wait cycles, pulse on the third.
        set_src(7, 16'h1234);
        drive(4'd7, 1'b1);
        tick();
        expect_out("slow_w1", 1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        drive(4'd0, 1'b0);
        tick();
        expect_out("slow_w2", 1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("slow_done", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        drive(4'd0, 1'b0);
        tick();
        check("slow_after.dv", {31'd0, data_valid}, 32'h0);

        // Slow select with DRAM changing mid-wait and a select offered during
        // the wait (must be ignored, including the addr latch).
        drive(4'd7, 1'b1);
        tick();
        check("slow2_w1.busy", {31'd0, busy}, 32'h1);
        drive(4'd2, 1'b1);
        set_src(7, 16'h5678);
        set_src(1, 16'h0099);
        tick();
        expect_out("slow2_w2", 1'b0, 16'h1234, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("slow2_done", 1'b1, 16'h5678, 1'b0, 1'b0, 1'b1);
        check("slow2_done.addr", {16'd0, addr}, 32'h0040);
        drive(4'd0, 1'b0);
        tick();
        check("slow2_nopulse.dv", {31'd0, data_valid}, 32'h0);
        check("slow2_nopulse.data", {16'd0, data_out}, 32'h5678);

        // Back-to-back fast selects PC, DR, IR.
        set_src(3, 16'h0001);
        set_src(4, 16'h0002);
        set_src(8, 16'h0003);
        drive(4'd3, 1'b1);
        tick();
        expect_out("b2b_pc", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
        check("b2b_pc.addr", {16'd0, addr}, 32'h0099);
        drive(4'd4, 1'b1);
        tick();
        expect_out("b2b_dr", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        drive(4'd8, 1'b1);
        tick();
        expect_out("b2b_ir", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1);

        // Illegal codes, then code 0.
        drive(4'd9, 1'b1);
        tick();
        expect_out("ill_9", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        drive(4'd15, 1'b1);
        tick();
        expect_out("ill_15", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        drive(4'd3, 1'b1);
        tick();
        expect_out("legal_again", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
        drive(4'd0, 1'b1);
        tick();
        expect_out("none", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        drive(4'd0, 1'b0);
        tick();
        expect_out("idle", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

`ifdef BUS_PARITY_EN
        set_src(2, 16'h0007);
        drive(4'd2, 1'b1);
        tick();
        check("par_7", {31'd0, data_par}, 32'h1);
        set_src(2, 16'h0003);
        drive(4'd2, 1'b1);
        tick();
        check("par_3", {31'd0, data_par}, 32'h0);
        drive(4'd0, 1'b0);
        tick();
`endif

        // Reset asserted mid-wait aborts the transfer.
        drive(4'd6, 1'b1);
        tick();
        check("abort_w1.busy", {31'd0, busy}, 32'h1);
        drive(4'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_out("abort_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("abort_rst.addr", {16'd0, addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("abort_after", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bus_xfer_ctrl
